cmp_serial: RTL and testbench

Parametrised, digit-serial magnitude comparator. Scans two WIDTH-bit operands one DIGIT-bit digit per clock, MSB first, and stops at the first differing digit. Evaluates one of six relations (EQ, NE, LT, LE, GT, GE) on unsigned or two's-complement operands. Sits in the datapath wherever a compare result may take several cycles in exchange for small area, with valid/ready handshakes on both sides.

---
 rtl/cmp_pkg.sv | 36 +++
 rtl/cmp_serial_if.sv | 35 +++
 rtl/cmp_digit.sv | 14 +
 rtl/cmp_serial.sv | 121 ++++++++++++
 tb/tb_cmp_serial.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the digit-serial comparator: relation encodings,
// FSM state type and the relation decode used on the result output.
package cmp_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_EQ = 3'b000;
  localparam op_t OP_NE = 3'b001;
  localparam op_t OP_LT = 3'b010;
  localparam op_t OP_LE = 3'b011;
  localparam op_t OP_GT = 3'b100;
  localparam op_t OP_GE = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reserved encodings decode to false so a bad op never reads as "true".
  function automatic logic cmp_result(input op_t op, input logic lt, input logic eq);
    logic r;
    r = 1'b0;
    case (op)
      OP_EQ:   r = eq;
      OP_NE:   r = ~eq;
      OP_LT:   r = lt;
      OP_LE:   r = lt | eq;
      OP_GT:   r = ~lt & ~eq;
      OP_GE:   r = ~lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_serial_if.sv
// Request/response handshake bundle for cmp_serial; the master drives
// requests and accepts results, the slave is the comparator itself.
interface cmp_serial_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
);
  import cmp_pkg::*;

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  op_t              op;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             out_lt;
  logic             out_eq;
  logic [CW-1:0]    out_digits;

  modport master (
    output in_valid, i0, i1, op, is_signed, out_ready,
    input  in_ready, out_valid, result, out_lt, out_eq, out_digits
  );

  modport slave (
    input  in_valid, i0, i1, op, is_signed, out_ready,
    output in_ready, out_valid, result, out_lt, out_eq, out_digits
  );

endinterface

// File: rtl/cmp_digit.sv
// Single-digit unsigned magnitude compare; purely combinational.
module cmp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/cmp_serial.sv
// Digit-serial magnitude comparator: scans operands MSB-first one digit per
// clock and stops at the first differing digit.
module cmp_serial
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  cmp_serial_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int PW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_width
    $fatal(1, "cmp_serial: WIDTH must be a multiple of DIGIT");
  end
  if (DIGIT != 1 && DIGIT != 2 && DIGIT != 4) begin : g_bad_digit
    $fatal(1, "cmp_serial: DIGIT must be 1, 2 or 4");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_t              r_op;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_lt;
  logic             r_eq;
  logic [CW-1:0]    r_digits;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic             w_dlt;
  logic             w_deq;
  logic             w_accept;
  logic             w_scan_end;
  logic [WIDTH-1:0] w_msb_flip;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_msb_flip = {bus.is_signed, {(WIDTH-1){1'b0}}};

  always_comb begin
    w_da = '0;
    w_db = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (r_ptr == PW'(k)) begin
        w_da = r_a[k*DIGIT +: DIGIT];
        w_db = r_b[k*DIGIT +: DIGIT];
      end
    end
  end

  cmp_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a  (w_da),
    .i_b  (w_db),
    .o_lt (w_dlt),
    .o_eq (w_deq)
  );

  assign w_accept   = (r_state == ST_IDLE) && bus.in_valid;
  assign w_scan_end = (r_state == ST_SCAN) && (!w_deq || (r_ptr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_scan_end)    w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture on accept, advance the digit pointer while scanning, latch flags at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_EQ;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_digits <= '0;
    end else if (w_accept) begin
      r_a   <= bus.i0 ^ w_msb_flip;
      r_b   <= bus.i1 ^ w_msb_flip;
      r_op  <= bus.op;
      r_ptr <= PW'(NDIG - 1);
      r_cnt <= '0;
    end else if (r_state == ST_SCAN) begin
      if (w_scan_end) begin
        r_lt     <= w_dlt;
        r_eq     <= w_deq;
        r_digits <= r_cnt + 1'b1;
      end else begin
        r_ptr <= r_ptr - 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.out_valid  = (r_state == ST_DONE);
  assign bus.result     = cmp_result(r_op, r_lt, r_eq);
  assign bus.out_lt     = r_lt;
  assign bus.out_eq     = r_eq;
  assign bus.out_digits = r_digits;

endmodule

// File: tb/tb_cmp_serial.sv
// Bench for cmp_serial (WIDTH=16, DIGIT=2): directed table, handshake corner
// sequences and randomized requests against an arithmetic reference model.
module tb_cmp_serial;

  localparam int WIDTH = 16;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  logic clk;
  logic rst_n;

  cmp_serial_if #(.WIDTH(WIDTH), .DIGIT(DIGIT)) bus ();

  cmp_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        sgn;
    logic        res;
    logic        lt;
    logic        eq;
    int          dig;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: relations from plain integer arithmetic, digit count from the
  // position of the highest differing bit.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic sgn, output logic res, output logic lt,
                       output logic eq, output int dig);
    longint av;
    longint bv;
    logic [15:0] x;
    int h;
    if (sgn) begin
      av = longint'($signed(a));
      bv = longint'($signed(b));
    end else begin
      av = longint'({48'd0, a});
      bv = longint'({48'd0, b});
    end
    lt = (av < bv);
    eq = (av == bv);
    case (op)
      3'd0: res = (av == bv);
      3'd1: res = (av != bv);
      3'd2: res = (av <  bv);
      3'd3: res = (av <= bv);
      3'd4: res = (av >  bv);
      3'd5: res = (av >= bv);
      default: res = 1'b0;
    endcase
    x = a ^ b;
    h = -1;
    for (int i = 0; i < 16; i++) if (x[i]) h = i;
    dig = (h < 0) ? NDIG : NDIG - h / DIGIT;
  endtask

  // Issue one request from an idle bench state and wait for out_valid.
  task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] op, input logic sgn, output int lat);
    bus.i0        = a;
    bus.i1        = b;
    bus.op        = op;
    bus.is_signed = sgn;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.i0        = 16'($urandom);
    bus.i1        = 16'($urandom);
    bus.op        = 3'($urandom);
    bus.is_signed = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] op, input logic sgn, input logic e_res,
                     input logic e_lt, input logic e_eq, input int e_dig);
    int lat;
    check({tag, " in_ready before"}, bus.in_ready, 1);
    start_and_wait(a, b, op, sgn, lat);
    check({tag, " latency"}, lat, e_dig);
    check({tag, " result"}, bus.result, e_res);
    check({tag, " out_lt"}, bus.out_lt, e_lt);
    check({tag, " out_eq"}, bus.out_eq, e_eq);
    check({tag, " out_digits"}, bus.out_digits, e_dig);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " in_ready after"}, bus.in_ready, 1);
    check({tag, " out_valid after"}, bus.out_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"}, bus.in_ready, 1);
    check({tag, " out_valid"}, bus.out_valid, 0);
    check({tag, " result"}, bus.result, 0);
    check({tag, " out_lt"}, bus.out_lt, 0);
    check({tag, " out_eq"}, bus.out_eq, 0);
    check({tag, " out_digits"}, bus.out_digits, 0);
  endtask

  initial begin
    int lat;
    logic r_res, r_lt, r_eq;
    int r_dig;
    logic [15:0] ra, rb;
    logic [2:0]  rop;
    logic        rsg;

    tbl[0] = '{16'h1234, 16'h1234, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8};
    tbl[1] = '{16'h8000, 16'h0001, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[2] = '{16'h8000, 16'h0001, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[3] = '{16'h00F0, 16'h00F1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8};
    tbl[4] = '{16'h00F0, 16'h00F1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8};
    tbl[5] = '{16'h0400, 16'h0000, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[6] = '{16'hFFFF, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[7] = '{16'h7FFF, 16'h8000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[8] = '{16'h0030, 16'h0020, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6};
    tbl[9] = '{16'h0102, 16'h0102, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.i0        = '0;
    bus.i1        = '0;
    bus.op        = '0;
    bus.is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      txn($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].sgn,
          tbl[i].res, tbl[i].lt, tbl[i].eq, tbl[i].dig);

    // Backpressure: result held while ignored in_valid pulses arrive.
    start_and_wait(16'h1111, 16'h2222, 3'd2, 1'b0, lat);
    check("bp latency", lat, 2);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1)) | (c == 2);
      bus.i0       = 16'h0000;
      bus.i1       = 16'h0000;
      bus.op       = 3'd0;
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", c), bus.out_valid, 1);
      check($sformatf("bp%0d in_ready", c), bus.in_ready, 0);
      check($sformatf("bp%0d result", c), bus.result, 1);
      check($sformatf("bp%0d out_lt", c), bus.out_lt, 1);
      check($sformatf("bp%0d out_digits", c), bus.out_digits, 2);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp in_ready after", bus.in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("bp pulse ignored", bus.out_valid, 0);

    // Asynchronous reset in the third scan cycle of a long scan.
    bus.i0 = 16'h0000; bus.i1 = 16'h0001; bus.op = 3'd2; bus.is_signed = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async rst");
    @(posedge clk); #1;
    check("rst held out_valid", bus.out_valid, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst out_valid", bus.out_valid, 0);
    txn("post rst", 16'h0005, 16'h0005, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8);

    // Random requests, biased toward shared prefixes and equal operands.
    for (int i = 0; i < 60; i++) begin
      ra  = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
        2:       rb = ra ^ 16'($urandom_range(0, 255));
        default: rb = 16'($urandom);
      endcase
      rop = 3'($urandom);
      rsg = 1'($urandom);
      model(ra, rb, rop, rsg, r_res, r_lt, r_eq, r_dig);
      txn($sformatf("rnd%0d", i), ra, rb, rop, rsg, r_res, r_lt, r_eq, r_dig);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
